// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus between the fetch unit, inst_rom and decode.
// master = fetch unit, slave = ROM/decode/alu side.
interface inst_fetch_unit_if;
  logic        stall;
  logic        branch_taken;
  logic        jump_taken;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
  logic [31:0] inst_count;

  modport master (
    input  stall,
    input  branch_taken,
    input  jump_taken,
    input  branch_offset,
    input  jump_index,
    input  rom_data,
    output rom_addr,
    output inst_out,
    output pc_out,
    output inst_valid,
    output inst_count
  );

  modport slave (
    output stall,
    output branch_taken,
    output jump_taken,
    output branch_offset,
    output jump_index,
    output rom_data,
    input  rom_addr,
    input  inst_out,
    input  pc_out,
    input  inst_valid,
    input  inst_count
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, issues ROM addresses, squashes the
// wrong-path fetch on branch/jump and holds under downstream stall.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_unit_if.master   bus
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_issued_pc;
  logic                  r_issued_valid;
  logic [31:0]           r_inst_count;
  logic [1:0]            r_state;

  logic [ADDR_WIDTH-1:0] w_seq_pc;
  logic [ADDR_WIDTH-1:0] w_link;
  logic [ADDR_WIDTH-1:0] w_jump_tgt;
  logic [ADDR_WIDTH-1:0] w_br_tgt;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic                  w_jump;
  logic                  w_branch;
  logic                  w_redirect;
  logic                  w_deliver;

  assign w_seq_pc   = r_pc + 4;
  assign w_link     = r_issued_pc + 4;
  assign w_jump_tgt = {w_link[ADDR_WIDTH-1 -: 4],
                       bus.jump_index, 2'b00};
  assign w_br_tgt   = w_link + (bus.branch_offset << 2);

  // Outcomes only count for a live instruction; jump beats branch.
  assign w_jump     = r_issued_valid & bus.jump_taken;
  assign w_branch   = r_issued_valid & bus.branch_taken & ~w_jump;
  assign w_redirect = w_jump | w_branch;
  assign w_deliver  = r_issued_valid & ~bus.stall;

  always_comb begin
    w_redir_pc = w_seq_pc;
    unique case (1'b1)
      w_jump:   w_redir_pc = w_jump_tgt;
      w_branch: w_redir_pc = w_br_tgt;
      default:  w_redir_pc = w_seq_pc;
    endcase
  end

  // A redirect overrides a stall; the sequential fetch behind it is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc           <= RESET_PC;
      r_issued_pc    <= '0;
      r_issued_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc           <= w_redir_pc;
      r_issued_pc    <= r_pc;
      r_issued_valid <= 1'b0;
    end else if (!bus.stall) begin
      r_pc           <= w_seq_pc;
      r_issued_pc    <= r_pc;
      r_issued_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_count <= '0;
    end else if (w_deliver) begin
      r_inst_count <= r_inst_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      unique case (r_state)
        FILL:    r_state <= RUN;
        RUN:     r_state <= w_redirect ? SQUASH : RUN;
        SQUASH:  r_state <= RUN;
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.rom_addr   = r_pc;
  assign bus.pc_out     = r_issued_pc;
  assign bus.inst_valid = r_issued_valid;
  assign bus.inst_out   = bus.rom_data;
  assign bus.inst_count = r_inst_count;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: vector table plus redirect,
// stall+redirect, mid-bubble reset and PC wrap sequences.
module tb_inst_fetch_unit;

  logic clk;
  logic rst;

  inst_fetch_unit_if bus ();
  inst_fetch_unit_if wbus ();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .ADDR_WIDTH(32)) u_wrap (
    .clk (clk),
    .rst (rst),
    .bus (wbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: mem[a] = a>>2, registered; read enable holds the output when
  // the fetch unit holds its address.
  logic rom_en;
  assign rom_en = rst | ~bus.stall |
                  (bus.inst_valid & (bus.branch_taken | bus.jump_taken));
  always @(posedge clk) begin
    if (rom_en) bus.rom_data <= bus.rom_addr >> 2;
    wbus.rom_data <= wbus.rom_addr >> 2;
  end

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        jmp;
    logic [31:0] off;
    logic [25:0] jidx;
    logic        chk;
    logic [31:0] e_rom;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_v;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vec [NV];

  task automatic setv(input int i, input logic r, input logic s,
                      input logic b, input logic j,
                      input logic [31:0] off, input logic [25:0] ji,
                      input logic c, input logic [31:0] rom,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic v, input logic [31:0] cnt);
    vec[i].rst = r;    vec[i].stall = s;
    vec[i].br = b;     vec[i].jmp = j;
    vec[i].off = off;  vec[i].jidx = ji;
    vec[i].chk = c;    vec[i].e_rom = rom;
    vec[i].e_pc = pc;  vec[i].e_inst = ins;
    vec[i].e_v = v;    vec[i].e_cnt = cnt;
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic j, input logic [31:0] off,
                       input logic [25:0] ji);
    rst                = r;
    bus.stall          = s;
    bus.branch_taken   = b;
    bus.jump_taken     = j;
    bus.branch_offset  = off;
    bus.jump_index     = ji;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    wbus.stall         = 1'b0;
    wbus.branch_taken  = 1'b0;
    wbus.jump_taken    = 1'b0;
    wbus.branch_offset = 32'h0;
    wbus.jump_index    = 26'h0;

    //      i  rst st br jm off           jidx    chk rom      pc       inst     v  cnt
    setv( 0, 1, 0, 0, 0, 32'h0,        26'h0,  0, 32'h0,  32'h0,  32'h0,  0, 0);
    setv( 1, 1, 0, 0, 0, 32'h0,        26'h0,  1, 32'h0,  32'h0,  32'h0,  0, 0);
    setv( 2, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h0,  32'h0,  32'h0,  0, 0);
    setv( 3, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h4,  32'h0,  32'h0,  1, 0);
    setv( 4, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h8,  32'h4,  32'h1,  1, 1);
    setv( 5, 0, 0, 1, 0, 32'hFFFFFFFD, 26'h0,  1, 32'hC,  32'h8,  32'h2,  1, 2);
    setv( 6, 0, 0, 1, 0, 32'hFFFFFFFD, 26'h0,  1, 32'h0,  32'h0,  32'h0,  0, 3);
    setv( 7, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h4,  32'h0,  32'h0,  1, 3);
    setv( 8, 0, 0, 1, 1, 32'h5,        26'h10, 1, 32'h8,  32'h4,  32'h1,  1, 4);
    setv( 9, 0, 0, 0, 1, 32'h0,        26'h30, 1, 32'h40, 32'h0,  32'h0,  0, 5);
    setv(10, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h44, 32'h40, 32'h10, 1, 5);
    setv(11, 1, 0, 0, 0, 32'h0,        26'h0,  1, 32'h48, 32'h44, 32'h11, 1, 6);
    setv(12, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h0,  32'h0,  32'h0,  0, 0);
    setv(13, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h4,  32'h0,  32'h0,  1, 0);
    setv(14, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h8,  32'h4,  32'h1,  1, 1);
    setv(15, 0, 1, 0, 0, 32'h0,        26'h0,  1, 32'hC,  32'h8,  32'h2,  1, 2);
    setv(16, 0, 1, 0, 0, 32'h0,        26'h0,  1, 32'hC,  32'h8,  32'h2,  1, 2);
    setv(17, 0, 1, 0, 0, 32'h0,        26'h0,  1, 32'hC,  32'h8,  32'h2,  1, 2);
    setv(18, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'hC,  32'h8,  32'h2,  1, 2);
    setv(19, 0, 0, 0, 0, 32'h0,        26'h0,  1, 32'h10, 32'hC,  32'h3,  1, 3);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].rst, vec[i].stall, vec[i].br, vec[i].jmp,
            vec[i].off, vec[i].jidx);
      #1;
      if (vec[i].chk) begin
        chk($sformatf("v%0d.rom_addr", i), bus.rom_addr, vec[i].e_rom);
        chk($sformatf("v%0d.valid", i), {31'b0, bus.inst_valid},
            {31'b0, vec[i].e_v});
        chk($sformatf("v%0d.count", i), bus.inst_count, vec[i].e_cnt);
        if (vec[i].e_v) begin
          chk($sformatf("v%0d.pc_out", i), bus.pc_out, vec[i].e_pc);
          chk($sformatf("v%0d.inst", i), bus.inst_out, vec[i].e_inst);
        end
      end
    end

    // Stall together with a branch: redirect to 8+4+(2<<2)=20.
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0); #1;
    chk("sr.reset_rom", bus.rom_addr, 32'h0);
    @(negedge clk); #1;
    chk("sr.pc0", bus.pc_out, 32'h0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("sr.pc8", bus.pc_out, 32'h8);
    chk("sr.cnt2", bus.inst_count, 32'd2);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h2, 26'h0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0); #1;
    chk("sr.bubble_rom", bus.rom_addr, 32'd20);
    chk("sr.bubble_v", {31'b0, bus.inst_valid}, 32'd0);
    chk("sr.bubble_cnt", bus.inst_count, 32'd2);
    @(negedge clk); #1;
    chk("sr.tgt_pc", bus.pc_out, 32'd20);
    chk("sr.tgt_inst", bus.inst_out, 32'd5);
    chk("sr.tgt_v", {31'b0, bus.inst_valid}, 32'd1);

    // Reset arriving in the bubble of a jump to 0x80.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 26'h20);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0); #1;
    chk("mr.jrom", bus.rom_addr, 32'h80);
    chk("mr.jcnt", bus.inst_count, 32'd3);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("mr.v", {31'b0, bus.inst_valid}, 32'd0);
    chk("mr.rom", bus.rom_addr, 32'h0);
    chk("mr.cnt", bus.inst_count, 32'd0);
    chk("wr.rom0", wbus.rom_addr, 32'hFFFF_FFF8);
    chk("wr.v0", {31'b0, wbus.inst_valid}, 32'd0);
    @(negedge clk); #1;
    chk("mr.pc_after", bus.pc_out, 32'h0);
    chk("mr.v_after", {31'b0, bus.inst_valid}, 32'd1);
    chk("wr.pc1", wbus.pc_out, 32'hFFFF_FFF8);
    chk("wr.inst1", wbus.inst_out, 32'h3FFF_FFFE);
    chk("wr.rom1", wbus.rom_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wr.pc2", wbus.pc_out, 32'hFFFF_FFFC);
    chk("wr.rom2", wbus.rom_addr, 32'h0);
    @(negedge clk); #1;
    chk("wr.pc3", wbus.pc_out, 32'h0);
    chk("wr.inst3", wbus.inst_out, 32'h0);
    chk("wr.rom3", wbus.rom_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch initiator for the MIPS datapath: owns the program counter, drives word addresses into inst_rom and presents each returned instruction, with its PC, to decode (reg_file, muxes, sign_extender).
- Redirects the PC on alu branch/jump outcomes and squashes the wrong-path fetch.
- Honours a stall from downstream.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_WIDTH, 32, PC and rom_addr width. Only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  hold the current instruction and PC.
- branch_taken  in  1  alu_branch_out for the instruction on inst_out.
- jump_taken  in  1  alu_jump_out for the instruction on inst_out.
- branch_offset  in  32  sign_extender output (word offset).
- jump_index  in  26  instr[25:0] of the current instruction.
- rom_addr  out  32  byte address to inst_rom; equals the pc register.
- rom_data  in  32  inst_rom read data, valid one cycle after rom_addr.
- inst_out  out  32  current instruction; passthrough of rom_data.
- pc_out  out  32  address of inst_out.
- inst_valid  out  1  inst_out/pc_out hold a real, non-squashed instruction.
- inst_count  out  32  number of instructions delivered.

Behaviour:
- Registers:
  - pc: next address to issue.
  - issued_pc, issued_valid: the address issued last cycle and whether it is valid.
  - inst_count.
  - Mapping: rom_addr=pc; pc_out=issued_pc; inst_valid=issued_valid.
- Reset (rst=1 at a rising edge): pc<=RESET_PC, issued_pc<=0, issued_valid<=0, inst_count<=0. Reset overrides stall and redirect, including mid-redirect.
- FSM, derived from issued_valid and the redirect history:
  - FILL (after reset): go to RUN at the next edge.
  - RUN: on a redirect go to SQUASH; otherwise stay in RUN.
  - SQUASH: go to RUN at the next edge.
- Latency: address issued in cycle t; instruction visible on inst_out/pc_out in cycle t+1. The first valid instruction appears in the first cycle after the first non-reset edge.
- Redirect is considered only when inst_valid=1; branch_taken/jump_taken are ignored otherwise. Priority: jump > branch > sequential.
  - Jump target: {(pc_out+4)[31:28], jump_index, 2'b00}.
  - Branch target: pc_out + 4 + (branch_offset<<2), modulo 2^32.
- Redirect edge: pc<=target, issued_pc<=pc, issued_valid<=0 (squashes the sequential fetch). Result: exactly one bubble cycle, then the target instruction with inst_valid=1.
- Stall=1 with no redirect: pc, issued_pc, issued_valid and inst_count hold. rom_addr is unchanged, so rom_data and inst_out stay stable.
- Stall=1 together with a valid redirect: the redirect wins and the stall is ignored for that edge.
- Sequential edge (no stall, no redirect): pc<=pc+4, issued_pc<=pc, issued_valid<=1.
- inst_count increments by 1 at each edge where inst_valid=1, stall=0 and rst=0, including the edge that redirects. It wraps 2^32-1 -> 0.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC goes to 32'h0000_0000. Addresses stay word-aligned by construction; RESET_PC must be a multiple of 4.

Test Plan:
- Reset/fill. Stimulus: ROM mem[addr]=addr>>2; hold rst 2 cycles, then release. Required: rom_addr=0, then 4, 8, 12 on successive cycles; inst_valid=0 in the first cycle after release, then 1 with pc_out=0, inst_out=0; next cycles give pc_out=4/inst_out=1, pc_out=8/inst_out=2; inst_count=3 after three deliveries.
- Branch. Stimulus: at pc_out=8, branch_taken=1, branch_offset=32'hFFFF_FFFD. Required: next cycle rom_addr=0 and inst_valid=0; following cycle pc_out=0, inst_valid=1; no instruction at pc_out=12 ever reaches inst_valid=1.
- Jump over branch. Stimulus: at pc_out=4, jump_taken=1, branch_taken=1, jump_index=26'h10. Required: target 32'h40; one bubble, then pc_out=32'h40.
- Stall. Stimulus: stall=1 for 3 cycles at pc_out=8. Required: pc_out=8, inst_out=2, rom_addr=12 and inst_count held; on release pc_out=12.
- Stall+redirect and mid-op reset:
  - stall=1 with branch_taken=1 at pc_out=8, offset=2 -> redirect to 20 with one bubble.
  - rst=1 during the bubble -> inst_valid=0, rom_addr=RESET_PC, inst_count=0.
- Wrap. Stimulus: RESET_PC=32'hFFFF_FFF8. Required: pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
